// File: rtl/sobel_tile_sequencer.sv
// Sobel tile sequencer: zeroes the image perimeter, then walks 4x4 windows at stride 2
// and writes the 2x2 interior pixels returned by the edge-detector core.
module sobel_tile_sequencer #(
    parameter int IMG_WIDTH  = 400,
    parameter int IMG_HEIGHT = 300,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [8:0]        win_row,
    output logic [8:0]        win_col,
    input  logic              pix_valid,
    input  logic [3:0]        pix_data,
    output logic              pix_ready,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [3:0]        out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BORDER  = 3'd1,
        S_ISSUE   = 3'd2,
        S_COLLECT = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    localparam logic [8:0]        W_LAST     = 9'(IMG_WIDTH - 1);
    localparam logic [8:0]        H_LAST     = 9'(IMG_HEIGHT - 1);
    localparam logic [8:0]        H_EDGE     = 9'(IMG_HEIGHT - 2);
    localparam logic [8:0]        W_ORG_LAST = 9'(IMG_WIDTH - 4);
    localparam logic [8:0]        H_ORG_LAST = 9'(IMG_HEIGHT - 4);
    localparam logic [ADDR_W-1:0] W_A        = ADDR_W'(IMG_WIDTH);

    state_t              r_state;
    logic [1:0]          r_bphase;
    logic [8:0]          r_row;
    logic [8:0]          r_col;
    logic [1:0]          r_pix;
    logic                r_win_valid;
    logic                r_pix_ready;
    logic                r_out_we;
    logic [ADDR_W-1:0]   r_out_addr;
    logic [3:0]          r_out_data;
    logic                r_busy;
    logic                r_done;

    logic [8:0]          w_pix_row;
    logic [8:0]          w_pix_col;
    logic [8:0]          w_sel_row;
    logic [8:0]          w_sel_col;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_pix_hs;
    logic                w_win_hs;
    logic                w_last_org;

    assign w_pix_hs   = r_pix_ready & pix_valid;
    assign w_win_hs   = r_win_valid & win_ready;
    assign w_last_org = (r_row == H_ORG_LAST) && (r_col == W_ORG_LAST);

    // Pixel k of a window lands at (r+1+k[1], c+1+k[0]); BORDER addresses the counters directly.
    always_comb begin
        w_pix_row = r_row + 9'd1 + {8'd0, r_pix[1]};
        w_pix_col = r_col + 9'd1 + {8'd0, r_pix[0]};
        if (r_state == S_BORDER) begin
            w_sel_row = r_row;
            w_sel_col = r_col;
        end else begin
            w_sel_row = w_pix_row;
            w_sel_col = w_pix_col;
        end
        w_addr = ADDR_W'(w_sel_row) * W_A + ADDR_W'(w_sel_col);
    end

    // Frame sequencing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bphase    <= 2'd0;
            r_row       <= 9'd0;
            r_col       <= 9'd0;
            r_pix       <= 2'd0;
            r_win_valid <= 1'b0;
            r_pix_ready <= 1'b0;
            r_out_we    <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_out_we <= 1'b0;
            r_done   <= 1'b0;
            if (abort) begin
                // A pixel accepted in the abort cycle still reaches the buffer.
                r_state     <= S_IDLE;
                r_win_valid <= 1'b0;
                r_pix_ready <= 1'b0;
                r_busy      <= 1'b0;
                if (w_pix_hs) begin
                    r_out_we   <= 1'b1;
                    r_out_addr <= w_addr;
                    r_out_data <= pix_data;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state  <= S_BORDER;
                            r_bphase <= 2'd0;
                            r_row    <= 9'd0;
                            r_col    <= 9'd0;
                            r_pix    <= 2'd0;
                            r_busy   <= 1'b1;
                        end
                    end
                    S_BORDER: begin
                        r_out_we   <= 1'b1;
                        r_out_addr <= w_addr;
                        r_out_data <= 4'd0;
                        case (r_bphase)
                            2'd0: begin
                                if (r_col == W_LAST) begin
                                    r_bphase <= 2'd1;
                                    r_row    <= H_LAST;
                                    r_col    <= 9'd0;
                                end else begin
                                    r_col <= r_col + 9'd1;
                                end
                            end
                            2'd1: begin
                                if (r_col == W_LAST) begin
                                    r_bphase <= 2'd2;
                                    r_row    <= 9'd1;
                                    r_col    <= 9'd0;
                                end else begin
                                    r_col <= r_col + 9'd1;
                                end
                            end
                            2'd2: begin
                                if (r_row == H_EDGE) begin
                                    r_bphase <= 2'd3;
                                    r_row    <= 9'd1;
                                    r_col    <= W_LAST;
                                end else begin
                                    r_row <= r_row + 9'd1;
                                end
                            end
                            default: begin
                                if (r_row == H_EDGE) begin
                                    r_state     <= S_ISSUE;
                                    r_win_valid <= 1'b1;
                                    r_row       <= 9'd0;
                                    r_col       <= 9'd0;
                                end else begin
                                    r_row <= r_row + 9'd1;
                                end
                            end
                        endcase
                    end
                    S_ISSUE: begin
                        if (w_win_hs) begin
                            r_state     <= S_COLLECT;
                            r_win_valid <= 1'b0;
                            r_pix_ready <= 1'b1;
                            r_pix       <= 2'd0;
                        end
                    end
                    S_COLLECT: begin
                        if (w_pix_hs) begin
                            r_out_we   <= 1'b1;
                            r_out_addr <= w_addr;
                            r_out_data <= pix_data;
                            r_pix      <= r_pix + 2'd1;
                            if (r_pix == 2'd3) begin
                                r_pix_ready <= 1'b0;
                                if (w_last_org) begin
                                    r_state <= S_FINISH;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state     <= S_ISSUE;
                                    r_win_valid <= 1'b1;
                                    if (r_col == W_ORG_LAST) begin
                                        r_col <= 9'd0;
                                        r_row <= r_row + 9'd2;
                                    end else begin
                                        r_col <= r_col + 9'd2;
                                    end
                                end
                            end
                        end
                    end
                    S_FINISH: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_win_valid <= 1'b0;
                        r_pix_ready <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign win_valid = r_win_valid;
    assign win_row   = r_row;
    assign win_col   = r_col;
    assign pix_ready = r_pix_ready;
    assign out_we    = r_out_we;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_sobel_tile_sequencer.sv
// Directed bench for sobel_tile_sequencer on an 8x6 image; a write scoreboard is filled
// from the perimeter list and from each observed pixel handshake.
module tb_sobel_tile_sequencer;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int AW = 17;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  data;
    } sb_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          win_valid;
    logic          win_ready;
    logic [8:0]    win_row;
    logic [8:0]    win_col;
    logic          pix_valid;
    logic [3:0]    pix_data;
    logic          pix_ready;
    logic          out_we;
    logic [AW-1:0] out_addr;
    logic [3:0]    out_data;
    logic          busy;
    logic          done;

    sobel_tile_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
    );

    int  n_vec  = 0;
    int  n_fail = 0;
    int  n_done = 0;
    int  n_win  = 0;
    int  m_r, m_c, m_cur_r, m_cur_c, m_idx;
    int  pv_mode = 0;
    bit  m_pend  = 1'b0;
    bit  mon_en  = 1'b0;
    sb_t sb_q[$];
    int  wr_log[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic sb_t mk(input int a, input logic [3:0] d);
        sb_t e;
        e.addr = 32'(a);
        e.data = d;
        return e;
    endfunction

    task automatic begin_frame();
        sb_q.delete();
        wr_log.delete();
        m_r = 0; m_c = 0; m_idx = 0; n_win = 0; m_pend = 1'b0;
        for (int c = 0; c < W; c++) sb_q.push_back(mk(c, 4'd0));
        for (int c = 0; c < W; c++) sb_q.push_back(mk((H - 1) * W + c, 4'd0));
        for (int r = 1; r < H - 1; r++) sb_q.push_back(mk(r * W, 4'd0));
        for (int r = 1; r < H - 1; r++) sb_q.push_back(mk(r * W + W - 1, 4'd0));
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_done);
        int k;
        k = 0;
        while (n_done < exp_done && k < 2000) begin
            tick();
            k++;
        end
        tick(); tick(); tick();
        chk(tag, n_done, exp_done);
        chk({tag, "_busy_low"}, busy, 1'b0);
        chk({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    // Pixel-valid pattern and random result data.
    initial begin
        pix_valid = 1'b0;
        pix_data  = 4'd0;
        forever begin
            @(posedge clk);
            #1;
            pix_data = 4'($urandom);
            case (pv_mode)
                0:       pix_valid = 1'b1;
                1:       pix_valid = ~pix_valid;
                default: pix_valid = 1'b0;
            endcase
        end
    end

    // Monitor: write scoreboard, window-origin model and handshake rules.
    always @(negedge clk) begin
        if (mon_en) begin
            sb_t e;
            if (m_pend) chk("we_one_cycle_after_hs", out_we, 1'b1);
            m_pend = 1'b0;
            if (out_we) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_we", out_we, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    chk("wr_addr", out_addr, e.addr);
                    chk("wr_data", out_data, e.data);
                    wr_log.push_back(int'(out_addr));
                end
            end
            if (done) begin
                n_done++;
                chk("done_after_last_write", sb_q.size(), 0);
            end
            chk("vld_rdy_exclusive", win_valid & pix_ready, 1'b0);
            if (win_valid && win_ready) begin
                chk("win_row", win_row, m_r);
                chk("win_col", win_col, m_c);
                m_cur_r = m_r; m_cur_c = m_c; m_idx = 0;
                n_win++;
                if (m_c == W - 4) begin
                    m_c = 0;
                    m_r = m_r + 2;
                end else begin
                    m_c = m_c + 2;
                end
            end
            if (pix_valid && pix_ready) begin
                chk("pix_per_window", m_idx < 4, 1'b1);
                sb_q.push_back(mk((m_cur_r + 1 + m_idx / 2) * W + m_cur_c + 1 + m_idx % 2, pix_data));
                m_idx++;
                m_pend = 1'b1;
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; abort = 1'b0; win_ready = 1'b1;
        tick(); tick();
        start = 1'b1; abort = 1'b1;
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_win_valid", win_valid, 1'b0);
        chk("rst_pix_ready", pix_ready, 1'b0);
        chk("rst_out_we", out_we, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_win_row", win_row, 0);
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Full frame, always ready/valid.
        pv_mode = 0; win_ready = 1'b1;
        begin_frame();
        chk("f1_busy", busy, 1'b1);
        wait_done("f1_done", 1);
        chk("f1_windows", n_win, 6);
        chk("f1_writes", wr_log.size(), 48);
        chk("f1_first_addr", wr_log[0], 0);
        chk("f1_w24_a0", wr_log[44], 29);
        chk("f1_w24_a1", wr_log[45], 30);
        chk("f1_w24_a2", wr_log[46], 37);
        chk("f1_w24_a3", wr_log[47], 38);

        // Window stall, toggling pix_valid, ignored start while busy.
        pv_mode = 1; win_ready = 1'b0;
        begin_frame();
        k = 0;
        while (!win_valid && k < 200) begin tick(); k++; end
        chk("stall_win_seen", win_valid, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", win_valid, 1'b1);
            chk("stall_row", win_row, 0);
            chk("stall_col", win_col, 0);
            chk("stall_no_we", out_we, 1'b0);
            start = (i == 2);
            tick();
        end
        start = 1'b0;
        win_ready = 1'b1;
        wait_done("f2_done", 2);
        chk("f2_windows", n_win, 6);
        chk("f2_writes", wr_log.size(), 48);

        // Abort during the third window's collect phase.
        pv_mode = 0;
        begin_frame();
        k = 0;
        while (!(n_win == 3 && pix_ready) && k < 500) begin tick(); k++; end
        chk("abort_reached_collect", pix_ready, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_win_valid", win_valid, 1'b0);
        chk("abort_pix_ready", pix_ready, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk("abort_no_done", n_done, 2);
        chk("abort_sb_empty", sb_q.size(), 0);
        chk("abort_writes", wr_log.size(), 33);

        // Abort and start together in IDLE.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle", busy, 1'b0);
        tick(); tick();
        chk("abort_start_no_we", out_we, 1'b0);

        begin_frame();
        wait_done("f3_done", 3);
        chk("f3_restart_addr0", wr_log[0], 0);
        chk("f3_writes", wr_log.size(), 48);

        // Reset in the middle of the border sweep.
        begin_frame();
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        sb_q.delete();
        m_pend = 1'b0;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_out_we", out_we, 1'b0);
        chk("mrst_out_addr", out_addr, 0);
        chk("mrst_out_data", out_data, 0);
        chk("mrst_win_col", win_col, 0);
        chk("mrst_done", done, 1'b0);
        tick();
        chk("mrst_hold_busy", busy, 1'b0);
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        tick();
        begin_frame();
        wait_done("f4_done", 4);
        chk("f4_restart_addr0", wr_log[0], 0);
        chk("f4_writes", wr_log.size(), 48);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_tile_sequencer.md
SOBEL_TILE_SEQUENCER -- requirements
Module: sobel_tile_sequencer

Interface
REQ-001 Parameter IMG_WIDTH, default 400, image width in pixels; SHALL be even and at least 4.
REQ-002 Parameter IMG_HEIGHT, default 300, image height in pixels; SHALL be even and at least 4.
REQ-003 Parameter ADDR_W, default 17, output-buffer address width; SHALL satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.
REQ-004 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 start  in  1  one-cycle request to process one frame.
REQ-007 abort  in  1  synchronous frame abort.
REQ-008 win_valid  out  1  window origin offered to the edge-detector core.
REQ-009 win_ready  in  1  core accepts the window; the transfer occurs when win_valid and win_ready are both high.
REQ-010 win_row  out  9  top row of the 4x4 window.
REQ-011 win_col  out  9  left column of the 4x4 window.
REQ-012 pix_valid  in  1  core presents one result pixel.
REQ-013 pix_data  in  4  result pixel value.
REQ-014 pix_ready  out  1  sequencer accepts the result pixel.
REQ-015 out_we  out  1  write strobe to the output image buffer.
REQ-016 out_addr  out  ADDR_W  write address, row*IMG_WIDTH+col.
REQ-017 out_data  out  4  write data.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse when a frame completes.

Function
REQ-020 States SHALL be IDLE, BORDER, ISSUE, COLLECT and FINISH, with registered state.
REQ-021 IDLE: start=1 SHALL go to BORDER and clear the row, column and pixel counters; start outside IDLE SHALL be ignored.
REQ-022 BORDER SHALL write 0 to every perimeter pixel, one per cycle, in this order:
- row 0, cols 0..W-1;
- row H-1, cols 0..W-1;
- col 0, rows 1..H-2;
- col W-1, rows 1..H-2.
REQ-023 BORDER SHALL therefore issue exactly 2W+2(H-2) writes, then go to ISSUE with origin (0,0).
REQ-024 ISSUE: win_valid=1 and win_row/win_col SHALL hold stable until the handshake, then go to COLLECT.
REQ-025 Window origins SHALL step col 0,2,...,W-4, then row += 2 with col reset to 0; the last origin is (H-4,W-4).
REQ-026 COLLECT: pix_ready=1; the 4 accepted pixels SHALL map to (r+1,c+1), (r+1,c+2), (r+2,c+1), (r+2,c+2), in that order.
REQ-027 Each accepted pixel SHALL produce out_we=1 with the matching out_addr/out_data exactly one cycle after the handshake.
REQ-028 Cycles with pix_valid=0 SHALL not advance the pixel counter.
REQ-029 After the 4th pixel: if the origin was the last, go to FINISH; otherwise advance the origin and go to ISSUE.
REQ-030 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-031 win_valid and pix_ready SHALL never be high together; both SHALL be low in IDLE, BORDER and FINISH.
REQ-032 out_we SHALL be high only in BORDER writes or one cycle after a pixel handshake.
REQ-033 abort=1 in any state SHALL go to IDLE next cycle:
- no done pulse;
- a pixel accepted in the abort cycle is still written on the next cycle;
- no further writes follow.
REQ-034 abort and start together in IDLE: abort SHALL win and the block stays IDLE.
REQ-035 All arithmetic SHALL be unsigned; out_addr SHALL be computed at full ADDR_W with no truncation.

Reset
REQ-036 rst=1 SHALL force IDLE and clear all counters, overriding start and abort.
REQ-037 During rst, win_valid, pix_ready, out_we, busy and done SHALL be 0, and win_row, win_col, out_addr and out_data SHALL be 0.
REQ-038 rst asserted mid-frame SHALL suppress any pending out_we on the following cycle.

Verification (W=8, H=6 unless stated)
REQ-039 start with win_ready=1 and pix_valid=1 held high -> 24 border writes of 0, 6 windows (0,0),(0,2),(0,4),(2,0),(2,2),(2,4), 24 pixel writes, a single done pulse.
REQ-040 Window (2,4), pixels A,B,C,D -> out_addr 29,30,37,38 with data A,B,C,D, each one cycle after its handshake.
REQ-041 Hold win_ready=0 for 5 cycles -> win_valid stays high with win_row/win_col unchanged; no writes occur.
REQ-042 Toggle pix_valid every cycle -> exactly 4 writes per window with correct order and no duplicates.
REQ-043 Assert abort during the 3rd window's COLLECT -> IDLE next cycle, busy=0, no done; a new start restarts with BORDER.
REQ-044 Assert rst mid-BORDER, then start -> all outputs 0 during rst; the frame restarts at address 0.
REQ-045 Defaults 400x300 -> 1396 border writes, 29651 windows, done after the last write to address 119598.
